fpu_mantissa_normalizer: RTL and testbench
==========================================

Name: fpu_mantissa_normalizer

Overview:
- Sequential left-normalizer for 8087 extended-precision mantissas: 64-bit significand, 15-bit biased exponent.
- Consumes the leading-zero condition and applies it: shifts whole bytes while the top byte is zero, then single bits until the MSB is set, decrementing the exponent to match.
- Sits after the FPU add/sub and convert datapaths, ahead of rounding.
- Multi-cycle, start/done handshake.

Parameters:
- MANT_WIDTH, 64, significand width; must be a multiple of 8.
- EXP_WIDTH, 15, biased exponent width.
- CNT_WIDTH, 7, width of the total shift count; must satisfy 2^CNT_WIDTH > MANT_WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- mant_in  input  MANT_WIDTH  unnormalized significand.
- exp_in  input  EXP_WIDTH  biased exponent.
- busy  output  1  high from the start edge until the edge that raises done.
- done  output  1  one-cycle pulse; results valid from this cycle.
- mant_out  output  MANT_WIDTH  normalized significand.
- exp_out  output  EXP_WIDTH  adjusted exponent.
- shift_count  output  CNT_WIDTH  total bits shifted.
- zero  output  1  input significand was zero.
- denormal  output  1  exponent reached 0 with mant_out MSB still 0.

Behaviour:
- Reset (asynchronous, active-high): every output and internal register goes to 0; state IDLE. Takes effect immediately, including mid-operation; the in-flight operation is discarded with no done pulse.
- States: IDLE, SCAN, FIN.
- IDLE: on an edge with start=1, load mant_in/exp_in into working registers, clear shift_count/zero/denormal, set busy=1, go to SCAN.
- SCAN: one decision per cycle, in this priority order:
  - working mantissa == 0: set zero=1, exp=0, go to FIN.
  - top byte == 0 and exp >= 8: shift left by 8, exp -= 8, count += 8.
  - MSB == 0 and exp > 0: shift left by 1, exp -= 1, count += 1.
  - otherwise: set denormal = (MSB==0), go to FIN.
- FIN: not a separate cycle. The FIN transition edge drives done=1, busy=0, registers mant_out/exp_out/shift_count, and returns to IDLE.
- Latency: done is high in cycle 1 + B + b after the start edge (B = byte steps, b = bit steps). Best case cycle 1; worst case cycle 15.
- Outputs hold their values until the next accepted start.
- start while busy: ignored, no queuing.
- start in the same cycle done is high: state is already IDLE, so it is accepted.
- Byte steps never underflow the exponent. When exp < 8, the block falls back to bit steps, which stop at exp = 0.
- Arithmetic: unsigned; exp never wraps below 0.

Optional Feature:
- Macro: FPU_NORM_FAST_BYTE_EN.
- Defined: the byte phase collapses into SCAN's first cycle. A combinational leading-zero-byte count L (0..8) is computed over the loaded mantissa. Shift by 8*min(L, exp>>3) bytes in one cycle, with matching exp and count updates; L==8 means zero. Bit steps then proceed as above. Worst-case done moves to cycle 9.
- Undefined: iterative byte steps, one per cycle, as specified in Behaviour.
- Final mant_out/exp_out/shift_count/zero/denormal values are identical in both modes.

Decomposition:
- Shared FPU package:
  - MANT_WIDTH, EXP_WIDTH, CNT_WIDTH constants.
  - State enum (IDLE/SCAN/FIN).
  - Constant EXP_BIAS = 15'h3FFF.
- Sub-module fpu_lzb_count: 8 byte-zero flags -> 4-bit leading-zero-byte count. Instantiated only under FPU_NORM_FAST_BYTE_EN.

Test Plan:
- mant_in=64'h8000_0000_0000_0000, exp_in=15'h3FFF -> done cycle 1; mant_out unchanged; exp_out=3FFF; shift_count=0; zero=0; denormal=0.
- mant_in=64'h1, exp_in=15'h3FFF -> mant_out=64'h8000_0000_0000_0000, exp_out=15'h3FC0, shift_count=63. done cycle 15, or cycle 9 with FPU_NORM_FAST_BYTE_EN.
- mant_in=0, exp_in=15'h1234 -> done cycle 1; zero=1; exp_out=0; mant_out=0; shift_count=0.
- mant_in=64'hFF, exp_in=5 -> no byte steps; mant_out=64'h1FE0, exp_out=0, shift_count=5, denormal=1, done cycle 6.
- Second start pulsed at cycle 3 of the mant_in=64'h1 case -> ignored; results match the first operation; exactly one done pulse.
- Reset asserted mid-SCAN (cycle 4) -> busy/done/outputs 0 immediately, no done pulse; next start with 64'h0000_0100_0000_0000, exp 3FFF -> shift_count=23, exp_out=15'h3FE8.

Source files
------------

// File: rtl/fpu_mantissa_normalizer_pkg.sv
// Shared FPU constants and the normalizer state type.
package fpu_mantissa_normalizer_pkg;

    localparam int FPU_MANT_WIDTH = 64;
    localparam int FPU_EXP_WIDTH  = 15;
    localparam int FPU_CNT_WIDTH  = 7;

    localparam logic [FPU_EXP_WIDTH-1:0] EXP_BIAS = 15'h3FFF;

    // FIN is a transition taken on the finishing edge; the state register never rests in it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } norm_state_e;

endpackage

// File: rtl/fpu_mantissa_normalizer_lzb_count.sv
// Leading-zero-byte counter: counts zero bytes from the most significant byte down.
module fpu_lzb_count #(
    parameter int NBYTES = 8,
    parameter int CW     = 4
) (
    input  logic [NBYTES-1:0] byte_zero,
    output logic [CW-1:0]     lzb
);

    logic found;

    // Walk from the top byte and stop counting at the first non-zero byte.
    always_comb begin
        lzb   = '0;
        found = 1'b0;
        for (int i = NBYTES - 1; i >= 0; i--) begin
            if (!found) begin
                if (byte_zero[i]) begin
                    lzb = lzb + 1'b1;
                end else begin
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpu_mantissa_normalizer.sv
// Sequential left-normalizer for extended-precision mantissas.
// Optional macro FPU_NORM_FAST_BYTE_EN: collapse the byte-shift phase into one cycle.
//
// state | meaning
// IDLE  | waiting for start; results held on outputs
// SCAN  | one shift decision per cycle (zero / byte / bit / finish)
// FIN   | finishing transition: publish results, pulse done, back to IDLE
module fpu_mantissa_normalizer
    import fpu_mantissa_normalizer_pkg::*;
#(
    parameter int MANT_WIDTH = FPU_MANT_WIDTH,
    parameter int EXP_WIDTH  = FPU_EXP_WIDTH,
    parameter int CNT_WIDTH  = FPU_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MANT_WIDTH-1:0] mant_in,
    input  logic [EXP_WIDTH-1:0]  exp_in,
    output logic                  busy,
    output logic                  done,
    output logic [MANT_WIDTH-1:0] mant_out,
    output logic [EXP_WIDTH-1:0]  exp_out,
    output logic [CNT_WIDTH-1:0]  shift_count,
    output logic                  zero,
    output logic                  denormal
);

    norm_state_e           state_q, state_d;
    logic [MANT_WIDTH-1:0] work_mant, mant_d, mant_out_d;
    logic [EXP_WIDTH-1:0]  work_exp, exp_d, exp_out_d;
    logic [CNT_WIDTH-1:0]  work_cnt, cnt_d, cnt_out_d;
    logic                  busy_d, done_d, zero_d, denorm_d;
    logic                  top_byte_zero;

    assign top_byte_zero = (work_mant[MANT_WIDTH-1 -: 8] == 8'h00);

`ifdef FPU_NORM_FAST_BYTE_EN
    localparam int NBYTES = MANT_WIDTH / 8;
    localparam int LZB_W  = $clog2(NBYTES + 1);

    logic                  first_q, first_d;
    logic [NBYTES-1:0]     byte_zero;
    logic [LZB_W-1:0]      lzb;
    logic [LZB_W-1:0]      fast_bytes;
    logic [EXP_WIDTH-1:0]  exp_bytes;
    logic [CNT_WIDTH-1:0]  fast_bits;

    for (genvar i = 0; i < NBYTES; i++) begin : g_byte_zero
        assign byte_zero[i] = (work_mant[8*i +: 8] == 8'h00);
    end

    fpu_lzb_count #(
        .NBYTES (NBYTES),
        .CW     (LZB_W)
    ) u_lzb_count (
        .byte_zero (byte_zero),
        .lzb       (lzb)
    );

    assign exp_bytes = work_exp >> 3;

    // Byte shift is limited by what the exponent can absorb without going negative.
    always_comb begin
        fast_bytes = lzb;
        if (exp_bytes < EXP_WIDTH'(lzb)) begin
            fast_bytes = exp_bytes[LZB_W-1:0];
        end
    end

    assign fast_bits = CNT_WIDTH'({fast_bytes, 3'b000});
`endif

    // Next-state, working-register and output decisions.
    always_comb begin
        state_d    = state_q;
        mant_d     = work_mant;
        exp_d      = work_exp;
        cnt_d      = work_cnt;
        busy_d     = busy;
        done_d     = 1'b0;
        mant_out_d = mant_out;
        exp_out_d  = exp_out;
        cnt_out_d  = shift_count;
        zero_d     = zero;
        denorm_d   = denormal;
`ifdef FPU_NORM_FAST_BYTE_EN
        first_d    = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mant_d    = mant_in;
                    exp_d     = exp_in;
                    cnt_d     = '0;
                    cnt_out_d = '0;
                    zero_d    = 1'b0;
                    denorm_d  = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SCAN;
`ifdef FPU_NORM_FAST_BYTE_EN
                    first_d   = 1'b1;
`endif
                end
            end
            SCAN: begin
`ifdef FPU_NORM_FAST_BYTE_EN
                first_d = 1'b0;
`endif
                if (work_mant == '0) begin
                    zero_d  = 1'b1;
                    exp_d   = '0;
                    state_d = FIN;
                end
`ifdef FPU_NORM_FAST_BYTE_EN
                else if (first_q && (fast_bytes != '0)) begin
                    mant_d = work_mant << fast_bits;
                    exp_d  = work_exp - EXP_WIDTH'(fast_bits);
                    cnt_d  = work_cnt + fast_bits;
                end
`endif
                else if (top_byte_zero && (work_exp >= EXP_WIDTH'(8))) begin
                    mant_d = work_mant << 8;
                    exp_d  = work_exp - EXP_WIDTH'(8);
                    cnt_d  = work_cnt + CNT_WIDTH'(8);
                end else if (!work_mant[MANT_WIDTH-1] && (work_exp != '0)) begin
                    mant_d = work_mant << 1;
                    exp_d  = work_exp - EXP_WIDTH'(1);
                    cnt_d  = work_cnt + CNT_WIDTH'(1);
                end else begin
                    denorm_d = !work_mant[MANT_WIDTH-1];
                    state_d  = FIN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == FIN) begin
            mant_out_d = work_mant;
            exp_out_d  = exp_d;
            cnt_out_d  = work_cnt;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
        end
    end

    // State, working and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            work_mant   <= '0;
            work_exp    <= '0;
            work_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mant_out    <= '0;
            exp_out     <= '0;
            shift_count <= '0;
            zero        <= 1'b0;
            denormal    <= 1'b0;
`ifdef FPU_NORM_FAST_BYTE_EN
            first_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            work_mant   <= mant_d;
            work_exp    <= exp_d;
            work_cnt    <= cnt_d;
            busy        <= busy_d;
            done        <= done_d;
            mant_out    <= mant_out_d;
            exp_out     <= exp_out_d;
            shift_count <= cnt_out_d;
            zero        <= zero_d;
            denormal    <= denorm_d;
`ifdef FPU_NORM_FAST_BYTE_EN
            first_q     <= first_d;
`endif
        end
    end

endmodule

// File: tb/tb_fpu_mantissa_normalizer.sv
// Self-checking bench for fpu_mantissa_normalizer (either FPU_NORM_FAST_BYTE_EN setting).
module tb_fpu_mantissa_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] mant_in;
    logic [14:0] exp_in;
    logic        busy, done, zero, denormal;
    logic [63:0] mant_out;
    logic [14:0] exp_out;
    logic [6:0]  shift_count;

    int checks   = 0;
    int failures = 0;

    fpu_mantissa_normalizer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mant_in     (mant_in),
        .exp_in      (exp_in),
        .busy        (busy),
        .done        (done),
        .mant_out    (mant_out),
        .exp_out     (exp_out),
        .shift_count (shift_count),
        .zero        (zero),
        .denormal    (denormal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] mant;
        logic [14:0] expo;
        logic [63:0] mo;
        logic [14:0] eo;
        logic [6:0]  cnt;
        logic        z;
        logic        dn;
        int          lat_slow;
        int          lat_fast;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp_v);
        end
    endtask

    // Reference: count leading zeros, then apply the byte/bit shift limits arithmetically.
    task automatic model(input logic [63:0] m, input logic [14:0] e,
                         output logic [63:0] mo, output logic [14:0] eo, output logic [6:0] c,
                         output logic z, output logic dn, output int lat);
        int lz, nb, nbit, e1, total;
        if (m == 64'd0) begin
            mo = '0; eo = '0; c = '0; z = 1'b1; dn = 1'b0; lat = 1;
            return;
        end
        lz = 0;
        while (m[63 - lz] == 1'b0) lz++;
        nb    = (lz / 8 < int'(e) / 8) ? lz / 8 : int'(e) / 8;
        e1    = int'(e) - 8 * nb;
        nbit  = (lz - 8 * nb < e1) ? lz - 8 * nb : e1;
        total = 8 * nb + nbit;
        mo    = m << total;
        eo    = 15'(int'(e) - total);
        c     = 7'(total);
        z     = 1'b0;
        dn    = (lz > total);
`ifdef FPU_NORM_FAST_BYTE_EN
        lat   = 1 + ((nb > 0) ? 1 : 0) + nbit;
`else
        lat   = 1 + nb + nbit;
`endif
    endtask

    // One operation: start, watch for done within a bounded window, check results and hold.
    task automatic run_op(input string name, input logic [63:0] m, input logic [14:0] e,
                          input logic [63:0] mo, input logic [14:0] eo, input logic [6:0] c,
                          input logic z, input logic dn, input int lat_exp, input int inject);
        int lat, n_done;
        lat = 0;
        n_done = 0;
        @(negedge clk);
        mant_in = m;
        exp_in  = e;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, " busy_after_start"}, 64'(busy), 64'd1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == inject + 1) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    lat = k;
                    check({name, " busy_at_done"}, 64'(busy), 64'd0);
                    check({name, " mant_out"}, mant_out, mo);
                    check({name, " exp_out"}, 64'(exp_out), 64'(eo));
                    check({name, " shift_count"}, 64'(shift_count), 64'(c));
                    check({name, " zero"}, 64'(zero), 64'(z));
                    check({name, " denormal"}, 64'(denormal), 64'(dn));
                end
            end else if (lat == 0 && busy !== 1'b1) begin
                check({name, " busy_during_scan"}, 64'(busy), 64'd1);
            end
            if (k == inject) begin
                mant_in = 64'h0000_0000_00FF_0000;
                exp_in  = 15'h0011;
                start   = 1'b1;
            end
            if (lat != 0 && k >= lat + 3) break;
        end
        mant_in = '0;
        exp_in  = '0;
        check({name, " latency"}, 64'(lat), 64'(lat_exp));
        check({name, " done_pulses"}, 64'(n_done), 64'd1);
        check({name, " mant_hold"}, mant_out, mo);
        check({name, " exp_hold"}, 64'(exp_out), 64'(eo));
    endtask

    function automatic int pick_lat(input vec_t v);
`ifdef FPU_NORM_FAST_BYTE_EN
        return v.lat_fast;
`else
        return v.lat_slow;
`endif
    endfunction

    initial begin
        logic [63:0] m, mo;
        logic [14:0] e, eo;
        logic [6:0]  c;
        logic        z, dn;
        int          lat, sh;

        vecs[0] = '{64'h8000_0000_0000_0000, 15'h3FFF, 64'h8000_0000_0000_0000, 15'h3FFF, 7'd0,  1'b0, 1'b0, 1,  1};
        vecs[1] = '{64'h0000_0000_0000_0001, 15'h3FFF, 64'h8000_0000_0000_0000, 15'h3FC0, 7'd63, 1'b0, 1'b0, 15, 9};
        vecs[2] = '{64'h0,                   15'h1234, 64'h0,                   15'h0000, 7'd0,  1'b1, 1'b0, 1,  1};
        vecs[3] = '{64'h0000_0000_0000_00FF, 15'h0005, 64'h0000_0000_0000_1FE0, 15'h0000, 7'd5,  1'b0, 1'b1, 6,  6};
        vecs[4] = '{64'h0000_0100_0000_0000, 15'h3FFF, 64'h8000_0000_0000_0000, 15'h3FE8, 7'd23, 1'b0, 1'b0, 10, 9};
        vecs[5] = '{64'h0000_0000_0000_0001, 15'd20,   64'h0000_0000_0010_0000, 15'h0000, 7'd20, 1'b0, 1'b1, 7,  6};
        vecs[6] = '{64'h0F00_0000_0000_0000, 15'd0,    64'h0F00_0000_0000_0000, 15'h0000, 7'd0,  1'b0, 1'b1, 1,  1};
        vecs[7] = '{64'h00FF_0000_0000_0000, 15'd8,    64'hFF00_0000_0000_0000, 15'h0000, 7'd8,  1'b0, 1'b0, 2,  2};

        reset   = 1'b1;
        start   = 1'b0;
        mant_in = '0;
        exp_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset mant_out", mant_out, 64'd0);
        check("reset shift_count", 64'(shift_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mant, vecs[i].expo, vecs[i].mo, vecs[i].eo,
                   vecs[i].cnt, vecs[i].z, vecs[i].dn, pick_lat(vecs[i]), -10);
        end

        // Start pulsed during cycle 3 of a long operation must be ignored.
        run_op("busy_start", vecs[1].mant, vecs[1].expo, vecs[1].mo, vecs[1].eo,
               vecs[1].cnt, vecs[1].z, vecs[1].dn, pick_lat(vecs[1]), 3);

        // Reset mid-SCAN: everything clears at once and no done follows.
        @(negedge clk);
        mant_in = 64'h1;
        exp_in  = 15'h3FFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset mant_out", mant_out, 64'd0);
        check("midreset exp_out", 64'(exp_out), 64'd0);
        check("midreset shift_count", 64'(shift_count), 64'd0);
        check("midreset zero_denorm", 64'({zero, denormal}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int late_done;
            late_done = 0;
            for (int k = 0; k < 16; k++) begin
                @(posedge clk);
                #1;
                if (done) late_done++;
            end
            check("midreset no_done", 64'(late_done), 64'd0);
        end
        run_op("after_reset", vecs[4].mant, vecs[4].expo, vecs[4].mo, vecs[4].eo,
               vecs[4].cnt, vecs[4].z, vecs[4].dn, pick_lat(vecs[4]), -10);

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 150; i++) begin
            m  = {$urandom, $urandom};
            sh = $urandom_range(0, 64);
            m  = (sh == 64) ? 64'd0 : (m >> sh);
            if ($urandom_range(0, 1) == 1) e = 15'($urandom_range(0, 70));
            else e = 15'($urandom);
            model(m, e, mo, eo, c, z, dn, lat);
            run_op($sformatf("rand%0d", i), m, e, mo, eo, c, z, dn, lat, -10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
